// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - multi-cycle execute-stage ALU with valid/ready handshakes and iterative shift-add multiply
// Optional feature macro: ALU_FAST_MUL_EN (single-cycle combinational multiply instead of the MUL state)
module alu_mc #(
    parameter int  WORD_SIZE = 32,
    localparam int SHAMT_W   = $clog2(WORD_SIZE)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 validE,
    output logic                 readyE,
    input  logic [WORD_SIZE-1:0] srcAE,
    input  logic [WORD_SIZE-1:0] srcBE,
    input  logic [2:0]           ALUControlE,
    output logic                 validM,
    input  logic                 readyM,
    output logic [WORD_SIZE-1:0] resultM,
    output logic                 zeroM
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [2:0] OP_MUL = 3'b100;

    state_t               state_q, state_d;
    logic [WORD_SIZE-1:0] result_q, result_d;
    logic                 zero_q, zero_d;
    logic                 valid_q, valid_d;
    logic                 accept;

`ifndef ALU_FAST_MUL_EN
    logic [WORD_SIZE-1:0] mcand_q, mcand_d;
    logic [WORD_SIZE-1:0] mplier_q, mplier_d;
    logic [WORD_SIZE-1:0] acc_q, acc_d;
    logic [WORD_SIZE-1:0] acc_sum;
    logic [SHAMT_W-1:0]   cnt_q, cnt_d;
`endif

    function automatic logic [WORD_SIZE-1:0] alu_op(
        input logic [2:0]           op,
        input logic [WORD_SIZE-1:0] a,
        input logic [WORD_SIZE-1:0] b
    );
        logic [WORD_SIZE-1:0] r;
        r = '0;
        case (op)
            3'b000: r = a + b;
            3'b001: r = a - b;
            3'b010: r = a & b;
            3'b011: r = a | b;
            3'b100: begin
`ifdef ALU_FAST_MUL_EN
                r = a * b;
`else
                // Iterative datapath owns Mul in this build.
                r = '0;
`endif
            end
            3'b101: r = a ^ b;
            3'b110: r = a << b[SHAMT_W-1:0];
            3'b111: r = a >> b[SHAMT_W-1:0];
        endcase
        return r;
    endfunction

    assign readyE  = (state_q == S_IDLE) | ((state_q == S_DONE) & readyM);
    assign validM  = valid_q;
    assign resultM = result_q;
    assign zeroM   = zero_q;
    assign accept  = validE & readyE;

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        zero_d   = zero_q;
        valid_d  = valid_q;
`ifndef ALU_FAST_MUL_EN
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        acc_sum  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
`endif
        case (state_q)
            S_MUL: begin
`ifndef ALU_FAST_MUL_EN
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                acc_d    = acc_sum;
                cnt_d    = cnt_q + SHAMT_W'(1);
                if (cnt_q == SHAMT_W'(WORD_SIZE - 1)) begin
                    result_d = acc_sum;
                    zero_d   = (acc_sum == '0);
                    valid_d  = 1'b1;
                    state_d  = S_DONE;
                end
`else
                state_d = S_IDLE;
`endif
            end
            default: begin
                // DONE with readyM hands the result off; an accept in the same edge overrides.
                if ((state_q == S_DONE) && readyM) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end
                if (accept) begin
`ifndef ALU_FAST_MUL_EN
                    if (ALUControlE == OP_MUL) begin
                        mcand_d  = srcAE;
                        mplier_d = srcBE;
                        acc_d    = '0;
                        cnt_d    = '0;
                        valid_d  = 1'b0;
                        state_d  = S_MUL;
                    end else begin
                        result_d = alu_op(ALUControlE, srcAE, srcBE);
                        zero_d   = (alu_op(ALUControlE, srcAE, srcBE) == '0);
                        valid_d  = 1'b1;
                        state_d  = S_DONE;
                    end
`else
                    result_d = alu_op(ALUControlE, srcAE, srcBE);
                    zero_d   = (alu_op(ALUControlE, srcAE, srcBE) == '0);
                    valid_d  = 1'b1;
                    state_d  = S_DONE;
`endif
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            zero_q   <= 1'b0;
            valid_q  <= 1'b0;
`ifndef ALU_FAST_MUL_EN
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            valid_q  <= valid_d;
`ifndef ALU_FAST_MUL_EN
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// tb/tb_alu_mc.sv - randomized and directed checks of alu_mc against a transaction-level model
module tb_alu_mc;
    localparam int W = 32;
`ifdef ALU_FAST_MUL_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif
    localparam int MUL_LAT = FAST ? 1 : W + 1;
    localparam int MUL_LOW = FAST ? 0 : W;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         validE = 1'b0;
    logic         readyE;
    logic [W-1:0] srcAE = '0;
    logic [W-1:0] srcBE = '0;
    logic [2:0]   ALUControlE = '0;
    logic         validM;
    logic         readyM = 1'b0;
    logic [W-1:0] resultM;
    logic         zeroM;

    alu_mc #(.WORD_SIZE(W)) dut (
        .clk(clk), .reset(reset), .validE(validE), .readyE(readyE),
        .srcAE(srcAE), .srcBE(srcBE), .ALUControlE(ALUControlE),
        .validM(validM), .readyM(readyM), .resultM(resultM), .zeroM(zeroM)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: one held result slot plus a countdown for an in-flight multiply.
    bit           m_valid = 1'b0;
    logic [W-1:0] m_result = '0;
    logic [W-1:0] m_pending = '0;
    int           m_busy = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] ref_alu(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] p;
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: begin
                p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
                return p[W-1:0];
            end
            3'd5: return a ^ b;
            3'd6: return a << (b % W);
            default: return a >> (b % W);
        endcase
    endfunction

    task automatic step(input bit v, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit rm, output bit acc, output bit vm, output bit re);
        bit exp_ready;
        logic [W-1:0] r;
        @(negedge clk);
        validE = v; ALUControlE = op; srcAE = a; srcBE = b; readyM = rm;
        #1;
        exp_ready = (m_busy == 0) && (!m_valid || rm);
        check("validM", validM, m_valid);
        check("readyE", readyE, exp_ready);
        if (m_valid) begin
            check("resultM", resultM, m_result);
            check("zeroM", zeroM, m_result == '0);
        end
        vm = validM;
        re = readyE;
        acc = v && exp_ready;
        @(posedge clk);
        if (m_valid && rm) m_valid = 1'b0;
        if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0) begin
                m_valid = 1'b1;
                m_result = m_pending;
            end
        end
        if (acc) begin
            r = ref_alu(op, a, b);
            if (op == 3'd4 && !FAST) begin
                m_busy = W;
                m_pending = r;
            end else begin
                m_valid = 1'b1;
                m_result = r;
            end
        end
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        reset = 1'b1; validE = 1'b0; readyM = 1'b0;
        m_valid = 1'b0; m_busy = 0;
        #1;
        check("reset_validM", validM, 0);
        check("reset_resultM", resultM, 0);
        check("reset_zeroM", zeroM, 0);
        check("reset_readyE", readyE, 1);
        repeat (cycles) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run_op(input string name, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp_res, input int exp_lat, input int exp_low);
        bit acc, vm, re;
        int n, lat, low;
        n = 0; acc = 1'b0;
        while (!acc && n < 50) begin
            step(1'b1, op, a, b, 1'b1, acc, vm, re);
            n++;
        end
        check({name, "_accept"}, acc, 1);
        lat = 0; low = 0; vm = 1'b0;
        while (!vm && lat < 60) begin
            step(1'b0, 3'd0, '0, '0, 1'b0, acc, vm, re);
            lat++;
            if (!vm && !re) low++;
        end
        check({name, "_latency"}, lat, exp_lat);
        check({name, "_readyE_low"}, low, exp_low);
        check({name, "_result"}, resultM, exp_res);
        check({name, "_zero"}, zeroM, exp_res == '0);
        step(1'b0, 3'd0, '0, '0, 1'b1, acc, vm, re);
    endtask

    initial begin
        bit acc, vm, re;
        int low, vcount;
        do_reset(2);

        run_op("add", 3'd0, 32'h1, 32'h1, 32'h2, 1, 0);
        run_op("sub", 3'd1, 32'h5, 32'h5, 32'h0, 1, 0);
        run_op("xor", 3'd5, 32'hF0F0_F0F0, 32'hFFFF_0000, 32'h0F0F_F0F0, 1, 0);
        run_op("sll", 3'd6, 32'h1, 32'h21, 32'h2, 1, 0);
        run_op("srl", 3'd7, 32'h8000_0000, 32'd31, 32'h1, 1, 0);
        run_op("mul", 3'd4, 32'h0001_0001, 32'h3, 32'h0003_0003, MUL_LAT, MUL_LOW);
        run_op("mul_ff", 3'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, MUL_LAT, MUL_LOW);

        // Backpressure: held Or result, a pending Add ignored until readyM rises.
        step(1'b1, 3'd3, 32'h4000_0001, 32'h1, 1'b1, acc, vm, re);
        check("bp_accept_or", acc, 1);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 3'd0, 32'h7, 32'h8, 1'b0, acc, vm, re);
            check("bp_hold_result", resultM, 32'h4000_0001);
            check("bp_readyE", re, 0);
        end
        step(1'b1, 3'd0, 32'h7, 32'h8, 1'b1, acc, vm, re);
        check("bp_handoff_accept", acc, 1);
        step(1'b0, 3'd0, '0, '0, 1'b0, acc, vm, re);
        check("bp_new_result", resultM, 32'hF);
        step(1'b0, 3'd0, '0, '0, 1'b1, acc, vm, re);

        // Back-to-back adds with readyM held high.
        low = 0; vcount = 0;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 3'd0, 32'(i), 32'd10, 1'b1, acc, vm, re);
            if (!re) low++;
            if (i > 0 && vm) vcount++;
        end
        step(1'b0, 3'd0, '0, '0, 1'b1, acc, vm, re);
        if (vm) vcount++;
        check("b2b_readyE_low", low, 0);
        check("b2b_results", vcount, 4);

        // Reset in the middle of a multiply.
        step(1'b1, 3'd4, 32'h3, 32'h5, 1'b1, acc, vm, re);
        repeat (10) step(1'b0, 3'd0, '0, '0, 1'b0, acc, vm, re);
        do_reset(2);
        run_op("add_after_reset", 3'd0, 32'h2, 32'h3, 32'h5, 1, 0);

        for (int i = 0; i < 3000; i++) begin
            logic [W-1:0] a, b;
            a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            step($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), a, b,
                 $urandom_range(0, 3) != 0, acc, vm, re);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_mc.md
# alu_mc

Multi-cycle, parametrised execute-stage ALU: successor of the single-cycle combinational ALU. Accepts one operation per valid/ready handshake, registers the result, and holds it until the downstream stage takes it. Adds Xor/Sll/Srl, a WORD_SIZE-iteration shift-add multiplier and a zero flag. Sits between the decode/execute register and the memory stage.

## Interface
- WORD_SIZE, 32: operand/result width; must be a power of two, ≥ 8.
- SHAMT_W, $clog2(WORD_SIZE): shift-amount width (derived, not overridden).

- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- validE  in  1  operation request valid.
- readyE  out  1  block can accept an operation this cycle.
- srcAE  in  WORD_SIZE  operand A.
- srcBE  in  WORD_SIZE  operand B (low SHAMT_W bits = shift amount for Sll/Srl).
- ALUControlE  in  3  opcode.
- validM  out  1  resultM/zeroM hold a valid result.
- readyM  in  1  downstream accepts the result.
- resultM  out  WORD_SIZE  registered result.
- zeroM  out  1  resultM == 0, registered alongside resultM.

## Operation
- Opcodes: 000 Add, 001 Sub, 010 And, 011 Or, 100 Mul, 101 Xor, 110 Sll, 111 Srl. All eight defined; no default case.
- Arithmetic modulo 2^WORD_SIZE; Mul returns low WORD_SIZE bits of unsigned product; Srl is logical (zero fill); shift amount = srcBE[SHAMT_W-1:0], upper bits ignored.
- Accept = validE & readyE at a rising edge. Operands and opcode latched at accept; inputs ignored afterwards until next accept.
- States: IDLE, MUL, DONE.
  - IDLE: readyE=1, validM=0. Accept non-Mul → compute, load resultM/zeroM, go DONE. Accept Mul → load multiplicand/multiplier, clear accumulator and counter, go MUL.
  - MUL: readyE=0, validM=0. Each edge: if multiplier LSB=1 add multiplicand to accumulator; multiplicand <<1, multiplier >>1, counter+1. After WORD_SIZE iterations load resultM/zeroM, go DONE.
  - DONE: validM=1, resultM/zeroM stable. readyE = readyM. readyM=0 → stay. readyM=1 & no accept → IDLE. readyM=1 & accept → result handed off and new op starts in the same edge (non-Mul: stay DONE with new result; Mul: go MUL).
- validM, resultM, zeroM never change while validM=1 and readyM=0.
- Reset (any state, including mid-MUL): state IDLE, counter 0, resultM 0, zeroM 0, validM 0, readyE 1 after release; partial product discarded.

## Timing
- readyE is combinational from state and readyM; no combinational path from srcAE/srcBE/ALUControlE/validE to any output.
- Non-Mul latency: accept at edge N → validM high in cycle after edge N (1 cycle).
- Mul latency (iterative): accept at edge N → validM high after edge N+WORD_SIZE (WORD_SIZE+1 cycles); readyE low for WORD_SIZE cycles.
- Throughput: back-to-back non-Mul ops at 1/cycle when readyM held high.
- readyM asserted while validM=0 has no effect.

## Configuration
- ALU_FAST_MUL_EN defined: Mul is single-cycle like other ops (combinational multiply into resultM); MUL state and counter not synthesised; every op has 1-cycle latency.
- Undefined (default): iterative shift-add multiplier as above.

## Test plan
- Reset then Add 1+1, readyM=1 → resultM=2, zeroM=0, validM one cycle after accept; Sub 5-5 → resultM=0, zeroM=1.
- Xor 0xF0F0_F0F0 ^ 0xFFFF_0000 → 0x0F0F_F0F0; Sll 0x1 by srcBE=0x21 → 0x2 (shift 1, upper bits ignored); Srl 0x8000_0000 by 31 → 0x1.
- Mul 0x0001_0001 × 0x0000_0003 → 0x0003_0003 after exactly 33 cycles, readyE=0 for 32 cycles; Mul 0xFFFF_FFFF × 0xFFFF_FFFF → 0x0000_0001. With ALU_FAST_MUL_EN: same results after 1 cycle.
- Backpressure: Or 0x4000_0001 | 0x1 with readyM=0 for 5 cycles → resultM=0x4000_0001 held, readyE=0, new validE ignored; readyM=1 → result taken and pending op accepted same edge.
- Back-to-back: 4 Adds on consecutive cycles, readyM=1 → 4 results on consecutive cycles, readyE never low.
- Reset asserted at iteration 10 of a Mul → validM=0, resultM=0, readyE=1 after release; subsequent Add 2+3 → 5.
